pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It is the successor to the fixed-width stall-only stage registers between IF/ID/EX/MEM/WB. Unlike those, it sustains one transfer per cycle under backpressure, and its `in_ready` is driven only from state, with no combinational path from `out_ready`. It also supports a synchronous flush that turns the stage into a bubble for branch/jump squashes.

## Interface
Parameters:
- `DATA_W`, default 64: payload width, for example {PC+4, instruction}; must be ≥ 1.
- `ZERO_ON_FLUSH`, default 1: 1 = payload registers clear to 0 (NOP) on reset/flush; 0 = payload registers hold their value, and only the valid bits clear.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `flush`, in, 1: synchronous squash of all stage contents.
- `in_valid`, in, 1: upstream payload valid.
- `in_ready`, out, 1: stage can accept; function of registered state only.
- `in_data`, in, `DATA_W`: upstream payload.
- `out_valid`, out, 1: downstream payload valid.
- `out_ready`, in, 1: downstream accepts (0 = stall).
- `out_data`, out, `DATA_W`: downstream payload.
- `count`, out, 2: occupancy, 0–2.

## Operation
- Storage is made of:
  - a main register `main_data`/`main_v`, which drives `out_*`;
  - a skid register `skid_data`/`skid_v`.
- State machine, `state` in {EMPTY, ONE, FULL}:
  - EMPTY: `main_v`=0, `skid_v`=0.
  - ONE: `main_v`=1, `skid_v`=0.
  - FULL: both valid.
- Fire conditions: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state != FULL)`; `out_valid = main_v`; `out_data = main_data`; `count` = 0/1/2 for EMPTY/ONE/FULL.
- Transitions:
  - EMPTY: `in_fire` → ONE, `main <= in_data`.
  - ONE, `in_fire & out_fire` → ONE, `main <= in_data`.
  - ONE, `in_fire & !out_fire` → FULL, `skid <= in_data`.
  - ONE, `!in_fire & out_fire` → EMPTY.
  - ONE, no fire → hold.
  - FULL (`in_ready`=0): `out_fire` → ONE, `main <= skid`; else hold.
- Priority order: `rst` low > `flush` > handshake.
- Flush:
  - Next state is EMPTY; `main_v` and `skid_v` clear.
  - An input presented in the flush cycle is discarded, even if `in_ready`=1; upstream sees a fire but the data is dropped.
  - An output presented in the flush cycle counts as consumed if `out_ready`=1; downstream already sampled it.
  - When `ZERO_ON_FLUSH`=1, `main_data` and `skid_data` become 0.
- Ordering: FIFO; no payload is duplicated, dropped (except by flush/reset) or reordered.

## Timing
- Reset values, after the first rising edge with `rst`=0:
  - `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1, state EMPTY.
  - `skid_data`=0 regardless of `ZERO_ON_FLUSH`.
- Latency: 1 cycle. Data accepted at edge N appears on `out_data` after edge N when the stage was EMPTY, or was ONE with `out_fire` at N.
- Throughput: 1 transfer/cycle sustained with `out_ready`=1.
- Stall:
  - `out_ready` falling with a continuous input stream absorbs exactly one extra item into skid; `in_ready` drops the following cycle.
  - After `out_ready` rises, `in_ready` reasserts one cycle later.
- `out_valid`/`out_data` hold stable while `out_valid & !out_ready`.
- Reset mid-operation: all contents lost at that edge; no partial state survives.
- `flush` held for multiple cycles: the stage stays EMPTY with `in_ready`=1.

## Structure
- Shared package `pipe_pkg`:
  - typedef `pipe_state_t` enum: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Code 2'd3 is illegal: it is decoded as EMPTY, and an assertion flags it.
- No sub-module. The block is instantiated once per pipeline boundary (IF/ID, ID/EX, …) with `DATA_W` set per stage.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `in_valid`=1 and `in_data`=0xDEAD → `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1.
- Streaming: `out_ready`=1, push 0x1,0x2,0x3 on consecutive cycles → `out_data` shows 0x1,0x2,0x3 one cycle later each, `count` stays 1.
- Stall/skid: streaming 0x10,0x11,0x12, with `out_ready`=0 from the cycle 0x10 is first valid → `count`=2, `in_ready`=0, 0x12 held upstream. Then raise `out_ready` → outputs 0x10,0x11,0x12 in order, none lost.
- Flush while FULL: FULL with 0x20 (main) and 0x21 (skid), assert `flush` with `in_valid`=1 and 0x22 → next cycle `out_valid`=0, `count`=0, `out_data`=0 (`ZERO_ON_FLUSH`=1); 0x22 never appears.
- `ZERO_ON_FLUSH`=0: flush in state ONE holding 0x30 → `out_valid`=0, `out_data` remains 0x30.
- Reset mid-stream: FULL, then `rst`=0 for one cycle → EMPTY, `in_ready`=1. The next push of 0x40 appears alone after 1 cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and helpers for pipeline skid stages
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // The unused code 2'd3 is treated as EMPTY so a corrupted register drains safely
    function automatic pipe_state_t decode_state(input pipe_state_t s);
        return (s == ONE || s == FULL) ? s : EMPTY;
    endfunction

    function automatic logic [1:0] occupancy(input pipe_state_t s);
        return (s == FULL) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with 2-entry skid buffer and flush
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter bit ZERO_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    pipe_state_t       state, state_d, cur;
    logic [DATA_W-1:0] main_data, main_d, skid_data, skid_d;
    logic              in_fire, out_fire;

    assign cur       = decode_state(state);
    assign in_ready  = (cur != FULL);
    assign out_valid = (cur != EMPTY);
    assign out_data  = main_data;
    assign count     = occupancy(cur);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next state and payload: flush squashes everything, otherwise FIFO handshake moves
    always_comb begin
        state_d = cur;
        main_d  = main_data;
        skid_d  = skid_data;
        if (flush) begin
            state_d = EMPTY;
            main_d  = ZERO_ON_FLUSH ? '0 : main_data;
            skid_d  = ZERO_ON_FLUSH ? '0 : skid_data;
        end else begin
            case (cur)
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_data;
                    end
                end
                default: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
            endcase
        end
    end

    // State and payload registers; reset always clears payload to a NOP
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_d;
            main_data <= main_d;
            skid_data <= skid_d;
        end
    end

    illegal_state_code: assert property (@(posedge clk) disable iff (!rst)
        (state == EMPTY || state == ONE || state == FULL));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench comparing two stage variants against a FIFO model
module tb_pipe_skid_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         rdy0, vld0, rdy1, vld1;
    logic [W-1:0] dat0, dat1;
    logic [1:0]   cnt0, cnt1;

    int           total = 0;
    int           bad = 0;
    int           pend = 0;
    bit           armed = 1'b0;
    logic [W-1:0] exp_q[$];

    pipe_skid_stage #(.DATA_W(W), .ZERO_ON_FLUSH(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .count(cnt0)
    );

    pipe_skid_stage #(.DATA_W(W), .ZERO_ON_FLUSH(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .count(cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs; the model decides acceptance from its own occupancy
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f,
                       input logic rs, output logic fired);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        rst       = rs;
        fired     = armed && rs && !f && v && (exp_q.size() < 2);
        pend      = fired ? 1 : 0;
        if (fired) exp_q.push_back(d);
    endtask

    task automatic push(input logic [W-1:0] d, input logic r);
        logic f;
        f = 1'b0;
        for (int n = 0; n < 8 && !f; n++) cyc(1'b1, d, r, 1'b0, 1'b1, f);
        check("push_timeout", 32'(f), 32'd1);
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, f);
    endtask

    // Monitor: compare the presented output with the model head, then apply this cycle's events
    always @(negedge clk) begin
        int occ;
        if (armed) begin
            occ = exp_q.size() - pend;
            check("count0", 32'(cnt0), 32'(occ));
            check("count1", 32'(cnt1), 32'(occ));
            check("in_ready0", 32'(rdy0), 32'(occ < 2));
            check("in_ready1", 32'(rdy1), 32'(occ < 2));
            check("out_valid0", 32'(vld0), 32'(occ > 0));
            check("out_valid1", 32'(vld1), 32'(occ > 0));
            if (occ > 0) begin
                check("out_data0", 32'(dat0), 32'(exp_q[0]));
                check("out_data1", 32'(dat1), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (!rst || flush) exp_q.delete();
        if (!rst) armed = 1'b1;
        pend = 0;
    end

    initial begin
        logic f;
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, f);
        check("reset_data0", 32'(dat0), 32'd0);
        check("reset_data1", 32'(dat1), 32'd0);
        check("reset_valid", 32'(vld0), 32'd0);
        check("reset_ready", 32'(rdy0), 32'd1);
        check("reset_count", 32'(cnt0), 32'd0);

        cyc(1'b1, 16'h1, 1'b1, 1'b0, 1'b1, f);
        cyc(1'b1, 16'h2, 1'b1, 1'b0, 1'b1, f);
        check("stream_first", 32'(dat0), 32'h1);
        cyc(1'b1, 16'h3, 1'b1, 1'b0, 1'b1, f);
        check("stream_second", 32'(dat0), 32'h2);
        idle(2);

        cyc(1'b1, 16'h10, 1'b1, 1'b0, 1'b1, f);
        cyc(1'b1, 16'h11, 1'b0, 1'b0, 1'b1, f);
        cyc(1'b1, 16'h12, 1'b0, 1'b0, 1'b1, f);
        check("stall_accept", 32'(f), 32'd0);
        check("stall_ready", 32'(rdy0), 32'd0);
        check("stall_count", 32'(cnt0), 32'd2);
        push(16'h12, 1'b1);
        idle(3);

        cyc(1'b1, 16'h20, 1'b0, 1'b0, 1'b1, f);
        cyc(1'b1, 16'h21, 1'b0, 1'b0, 1'b1, f);
        cyc(1'b1, 16'h22, 1'b0, 1'b1, 1'b1, f);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, f);
        check("flush_full_data0", 32'(dat0), 32'd0);
        check("flush_full_data1", 32'(dat1), 32'h20);
        check("flush_full_count", 32'(cnt0), 32'd0);
        idle(2);

        cyc(1'b1, 16'h30, 1'b0, 1'b0, 1'b1, f);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, f);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, f);
        check("flush_one_hold1", 32'(dat1), 32'h30);
        check("flush_one_zero0", 32'(dat0), 32'd0);
        check("flush_one_valid1", 32'(vld1), 32'd0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h60 + 16'(i), 1'b1, 1'b1, 1'b1, f);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, f);
        check("multi_flush_ready", 32'(rdy0), 32'd1);

        cyc(1'b1, 16'h50, 1'b0, 1'b0, 1'b1, f);
        cyc(1'b1, 16'h51, 1'b0, 1'b0, 1'b1, f);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b1, 16'h40, 1'b1, 1'b0, 1'b1, f);
        check("midreset_ready", 32'(rdy0), 32'd1);
        check("midreset_count", 32'(cnt0), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, f);
        check("midreset_data", 32'(dat0), 32'h40);
        check("midreset_alone", 32'(cnt0), 32'd1);
        idle(2);

        for (int i = 0; i < 800; i++)
            cyc(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
                ($urandom % 25) == 0, ($urandom % 60) != 0, f);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
